// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: producer latencies and ID-stage control words.
package hazard_scoreboard_pkg;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;

    // {IF_ID_Write, PC_Write, Inst_src}
    localparam logic [2:0] CTRL_STALL = 3'b000;
    localparam logic [2:0] CTRL_PASS  = 3'b111;

    function automatic int sat_add(input int a, input int b, input int max_val);
        return (a + b > max_val) ? max_val : a + b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// sb_counter: one per-register countdown; a load wins over the decrement, which stops at zero.
module sb_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-tracking hazard scoreboard beside the ID stage; drives PC/IF-ID write and bubble select.
// Optional HAZARD_STATS_EN adds saturating stall_count and cond_stall_count outputs.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LAT  = 4,
    parameter int BR_EXTRA = 1,
    parameter int LAT_W    = $clog2(MAX_LAT + 1),
    parameter int CNT_W    = $clog2(MAX_LAT + BR_EXTRA + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hazard_en,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_cond,
    input  logic                id_wr_en,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic [LAT_W-1:0]    id_lat,
    output logic                IF_ID_Write,
    output logic                PC_Write,
    output logic                Inst_src,
    output logic [NUM_REGS-1:0] busy_mask
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_count,
    output logic [31:0]         cond_stall_count
`endif
);

    localparam int               CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] BR_LIM  = CNT_W'(BR_EXTRA);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] lat_clamped;
    logic [CNT_W-1:0] load_val;
    logic             rs_haz;
    logic             rt_haz;
    logic             stall;
    logic             issue;
    logic             load_any;
    logic [2:0]       ctrl;

    always_comb begin
        lat_clamped = (int'(id_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : id_lat;
        load_val    = CNT_W'(sat_add(int'(lat_clamped), BR_EXTRA, CNT_MAX));
    end

    // A condition consumer resolves in ID, so it waits the extra BR_EXTRA cycles a normal consumer skips.
    always_comb begin
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        if (id_use_rs && id_rs != '0) begin
            rs_haz = id_cond ? (cnt[id_rs] != '0) : (cnt[id_rs] > BR_LIM);
        end
        if (id_use_rt && id_rt != '0) begin
            rt_haz = id_cond ? (cnt[id_rt] != '0) : (cnt[id_rt] > BR_LIM);
        end
    end

    assign stall    = hazard_en && id_valid && (rs_haz || rt_haz);
    assign issue    = id_valid && !stall;
    assign load_any = issue && id_wr_en && (id_rd != '0);
    assign ctrl     = stall ? CTRL_STALL : CTRL_PASS;
    assign {IF_ID_Write, PC_Write, Inst_src} = ctrl;

    assign cnt[0]       = '0;
    assign busy_mask[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            sb_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .load    (load_any && (id_rd == REG_AW'(gi))),
                .load_val(load_val),
                .cnt     (cnt[gi])
            );
            assign busy_mask[gi] = (cnt[gi] != '0);
        end
    endgenerate

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_reg;
    logic [31:0] cond_stall_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_reg      <= '0;
            cond_stall_count_reg <= '0;
        end else begin
            if (stall && stall_count_reg != '1) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
            if (stall && id_cond && cond_stall_count_reg != '1) begin
                cond_stall_count_reg <= cond_stall_count_reg + 32'd1;
            end
        end
    end

    assign stall_count      = stall_count_reg;
    assign cond_stall_count = cond_stall_count_reg;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed latency scenarios plus random traffic against a ready-time model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int MAX_LAT  = 4;
    localparam int BR_EXTRA = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_en, id_valid, id_use_rs, id_use_rt, id_cond, id_wr_en;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_lat;
    logic        IF_ID_Write, PC_Write, Inst_src;
    logic [31:0] busy_mask;
    logic [2:0]  ctrl;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count, cond_stall_count;
`endif

    assign ctrl = {IF_ID_Write, PC_Write, Inst_src};

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS(32), .REG_AW(5), .MAX_LAT(MAX_LAT), .BR_EXTRA(BR_EXTRA)
    ) dut (
        .clk(clk), .rst(rst), .hazard_en(hazard_en), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_cond(id_cond), .id_wr_en(id_wr_en), .id_rd(id_rd), .id_lat(id_lat),
        .IF_ID_Write(IF_ID_Write), .PC_Write(PC_Write), .Inst_src(Inst_src),
        .busy_mask(busy_mask)
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count), .cond_stall_count(cond_stall_count)
`endif
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Model: absolute cycle at which each register's producer is fully retired.
    int cyc = 1;
    int done_at [32];
    int m_stalls = 0;
    int m_cond_stalls = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Normal consumers can issue at t+L+1, condition consumers BR_EXTRA cycles later.
    function automatic bit src_haz(input logic [4:0] s, input bit use_s, input bit cond);
        if (!use_s || s == 5'd0) return 1'b0;
        if (cond) return cyc < done_at[s];
        return cyc < done_at[s] - BR_EXTRA;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = '0;
        for (int r = 1; r < 32; r++) m[r] = (cyc < done_at[r]);
        return m;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) done_at[r] = 0;
        m_stalls = 0;
        m_cond_stalls = 0;
    endtask

    task automatic step(input bit v, input bit hen, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urs, input bit urt, input bit cond, input bit wr,
                        input logic [4:0] rd, input logic [2:0] lat, output bit stalled);
        bit exp_stall;
        int l;
        @(negedge clk);
        id_valid = v; hazard_en = hen; id_rs = rs; id_rt = rt; id_use_rs = urs;
        id_use_rt = urt; id_cond = cond; id_wr_en = wr; id_rd = rd; id_lat = lat;
        #1;
        exp_stall = hen && v && (src_haz(rs, urs, cond) || src_haz(rt, urt, cond));
        chk("ctrl", 64'(ctrl), exp_stall ? 64'(CTRL_STALL) : 64'(CTRL_PASS));
        chk("busy_mask", 64'(busy_mask), 64'(model_busy()));
        $display("cyc %0d v=%0b hen=%0b rs=%0d rt=%0d cond=%0b wr=%0b rd=%0d lat=%0d ctrl=%b busy=%h",
                 cyc, v, hen, rs, rt, cond, wr, rd, lat, ctrl, busy_mask);
        stalled = (ctrl == CTRL_STALL);
        @(posedge clk);
        l = (int'(lat) > MAX_LAT) ? MAX_LAT : int'(lat);
        if (v && !exp_stall && wr && rd != 5'd0) done_at[rd] = cyc + l + BR_EXTRA + 1;
        if (exp_stall) begin
            m_stalls++;
            if (cond) m_cond_stalls++;
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        bit s;
        step(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, s);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) idle();
    endtask

    // Hold one instruction in ID until it issues; returns how many cycles it stalled.
    task automatic issue(input string tag, input bit hen, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urs, input bit urt, input bit cond, input bit wr,
                         input logic [4:0] rd, input logic [2:0] lat, output int stalls);
        bit s;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, hen, rs, rt, urs, urt, cond, wr, rd, lat, s);
            if (!s) return;
            stalls++;
        end
        chk({tag, "_timeout"}, 64'(stalls), 64'd0);
    endtask

    initial begin
        int  n;
        bit  s;
        for (int r = 0; r < 32; r++) done_at[r] = 0;
        rst = 1'b1;
        hazard_en = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_cond = 1'b0; id_wr_en = 1'b0; id_rd = '0; id_lat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'(ctrl), 64'(CTRL_PASS));
        chk("reset_busy", 64'(busy_mask), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // load-use: lw r8 then add r8
        issue("lw8", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 3'(LAT_LOAD), n);
        issue("add_r8", 1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 3'(LAT_ALU), n);
        chk("load_use_stalls", 64'(n), 64'd1);
        idles(6);

        // ALU then branch, load then branch
        issue("add5", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 3'(LAT_ALU), n);
        issue("beq_rs5", 1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, n);
        chk("alu_branch_stalls", 64'(n), 64'd1);
        issue("lw5", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 3'(LAT_LOAD), n);
        issue("beq_rt5", 1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, n);
        chk("load_branch_stalls", 64'(n), 64'd2);
        idles(6);

        // register 0 is never tracked
        issue("lw0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 3'(LAT_LOAD), n);
        chk("r0_busy", 64'(busy_mask), 64'd0);
        issue("add_r0", 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 3'(LAT_ALU), n);
        chk("r0_stalls", 64'(n), 64'd0);
        idles(6);

        // hazard_en low: no stall but tracking continues
        issue("lw9", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 3'(LAT_LOAD), n);
        chk("hen_busy9", 64'(busy_mask[9]), 64'd1);
        issue("use9_hen0", 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, n);
        chk("hen_stalls", 64'(n), 64'd0);
        idles(6);

        // WAW: newer ALU writer replaces the multiply countdown
        issue("mul4", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 3'(LAT_MUL), n);
        issue("add4", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 3'(LAT_ALU), n);
        chk("waw_busy_1", 64'(busy_mask[4]), 64'd1);
        idle();
        chk("waw_busy_0", 64'(busy_mask[4]), 64'd0);
        idles(6);

        // latency clamp: lat 7 behaves as MAX_LAT, giving 5 busy cycles
        issue("clamp6", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 3'd7, n);
        n = 0;
        while (busy_mask[6] && n < 12) begin
            n++;
            idle();
        end
        chk("clamp_busy_cycles", 64'(n), 64'd5);
        idles(2);

        // asynchronous reset in the middle of a stall
        issue("lw8_rst", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 3'(LAT_LOAD), n);
        @(negedge clk);
        id_valid = 1'b1; hazard_en = 1'b1; id_rs = 5'd8; id_use_rs = 1'b1; id_use_rt = 1'b0;
        id_cond = 1'b0; id_wr_en = 1'b0;
        #1;
        chk("pre_rst_ctrl", 64'(ctrl), 64'(CTRL_STALL));
        rst = 1'b1;
        #1;
        chk("async_rst_ctrl", 64'(ctrl), 64'(CTRL_PASS));
        chk("async_rst_busy", 64'(busy_mask), 64'd0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;

        // stats sequence: load-use plus load-branch
        issue("st_lw8", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 3'(LAT_LOAD), n);
        issue("st_add8", 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 3'(LAT_ALU), n);
        issue("st_lw5", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 3'(LAT_LOAD), n);
        issue("st_beq5", 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, n);
`ifdef HAZARD_STATS_EN
        chk("stall_count", 64'(stall_count), 64'd3);
        chk("cond_stall_count", 64'(cond_stall_count), 64'd2);
`endif

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), s);
        end
`ifdef HAZARD_STATS_EN
        chk("rand_stall_count", 64'(stall_count), 64'(m_stalls));
        chk("rand_cond_stall_count", 64'(cond_stall_count), 64'(m_cond_stalls));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
